// File: rtl/fetch_buffer.sv
// Instruction-fetch front end: owns the PC, issues synchronous imem reads and
// buffers returned words in a QDEPTH-entry FIFO that feeds decode by valid/ready.
module fetch_buffer #(
    parameter int unsigned ADDR_W   = 7,
    parameter int unsigned QDEPTH   = 4,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic              clk,
    input  logic              rst,
    output logic              imem_en,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [31:0]       imem_rdata,
    input  logic              redirect,
    input  logic [31:0]       redirect_addr,
    output logic              d_valid,
    input  logic              d_ready,
    output logic [31:0]       d_inst,
    output logic [31:0]       d_pc,
    output logic [31:0]       bubble_cnt
);

    localparam int unsigned PW = $clog2(QDEPTH);
    localparam int unsigned CW = PW + 1;

    typedef logic [PW-1:0] ptr_t;
    typedef logic [CW-1:0] cnt_t;
    typedef logic [CW:0]   occ_t;

    logic [31:0] pc_q, pc_d;
    logic [31:0] reqPc_q, reqPc_d;
    logic        inflight_q, inflight_d;
    cnt_t        count_q, count_d;
    ptr_t        rdPtr_q, rdPtr_d;
    ptr_t        wrPtr_q, wrPtr_d;
    logic [31:0] bubble_q, bubble_d;
    logic [31:0] instMem_q [QDEPTH];
    logic [31:0] pcMem_q   [QDEPTH];

    logic pop;
    logic push;
    logic issue;
    occ_t occupancy;

    // Occupancy counts the in-flight word too, so an issue never outruns free space.
    assign d_valid   = (count_q != '0);
    assign pop       = d_valid & d_ready;
    assign push      = inflight_q & ~redirect;
    assign occupancy = occ_t'(count_q) + occ_t'(inflight_q) - occ_t'(pop);
    assign issue     = ~rst & ~redirect & (occupancy < occ_t'(QDEPTH));

    assign imem_en    = issue;
    assign imem_addr  = rst ? RESET_PC[ADDR_W+1:2] : pc_q[ADDR_W+1:2];
    assign d_inst     = d_valid ? instMem_q[rdPtr_q] : 32'd0;
    assign d_pc       = d_valid ? pcMem_q[rdPtr_q]   : 32'd0;
    assign bubble_cnt = bubble_q;

    always_comb begin
        pc_d       = pc_q;
        reqPc_d    = reqPc_q;
        inflight_d = inflight_q;
        count_d    = count_q;
        rdPtr_d    = rdPtr_q;
        wrPtr_d    = wrPtr_q;
        bubble_d   = bubble_q;

        if (redirect) begin
            pc_d       = redirect_addr & 32'hFFFF_FFFC;
            count_d    = '0;
            rdPtr_d    = '0;
            wrPtr_d    = '0;
            inflight_d = 1'b0;
        end else begin
            if (pop) begin
                rdPtr_d = rdPtr_q + 1'b1;
            end
            if (push) begin
                wrPtr_d = wrPtr_q + 1'b1;
            end
            if (push && !pop) begin
                count_d = count_q + 1'b1;
            end else if (pop && !push) begin
                count_d = count_q - 1'b1;
            end
            if (issue) begin
                reqPc_d    = pc_q;
                inflight_d = 1'b1;
                pc_d       = pc_q + 32'd4;
            end else begin
                inflight_d = 1'b0;
            end
        end

        // Bubbles are counted across redirects; only reset clears the counter.
        if (d_ready && !d_valid && !(&bubble_q)) begin
            bubble_d = bubble_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q       <= RESET_PC;
            reqPc_q    <= RESET_PC;
            inflight_q <= 1'b0;
            count_q    <= '0;
            rdPtr_q    <= '0;
            wrPtr_q    <= '0;
            bubble_q   <= 32'd0;
        end else begin
            pc_q       <= pc_d;
            reqPc_q    <= reqPc_d;
            inflight_q <= inflight_d;
            count_q    <= count_d;
            rdPtr_q    <= rdPtr_d;
            wrPtr_q    <= wrPtr_d;
            bubble_q   <= bubble_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && push) begin
            instMem_q[wrPtr_q] <= imem_rdata;
            pcMem_q[wrPtr_q]   <= reqPc_q + 32'd4;
        end
    end

endmodule

// File: tb/tb_fetch_buffer.sv
// Directed and seeded-random bench for fetch_buffer at QDEPTH 4, 2 and 8, all
// fed the same stimulus and each checked every cycle against a reference model.
module tb_fetch_buffer;

    localparam logic [31:0] RESET_PC_TB = 32'h0;

    logic        clk = 1'b0;
    logic        rst;
    logic        redirect;
    logic [31:0] redirectAddr;
    logic        dReady;

    logic        imemEn    [3];
    logic [6:0]  imemAddr  [3];
    logic [31:0] imemRdata [3];
    logic        dValid    [3];
    logic [31:0] dInst     [3];
    logic [31:0] dPc       [3];
    logic [31:0] bubbleCnt [3];

    int compared   = 0;
    int mismatched = 0;

    logic [31:0] mPc     [3];
    logic [31:0] mReqPc  [3];
    logic [31:0] mBubble [3];
    logic        mInfl   [3];
    int          mCount  [3];
    int          mHead   [3];
    logic [31:0] mInst   [3][8];
    logic [31:0] mDpc    [3][8];
    int          obsCount[3];
    logic        obsInfl [3];

    always #5 clk = ~clk;

    fetch_buffer #(.ADDR_W(7), .QDEPTH(4), .RESET_PC(RESET_PC_TB)) dut4 (
        .clk(clk), .rst(rst), .imem_en(imemEn[0]), .imem_addr(imemAddr[0]),
        .imem_rdata(imemRdata[0]), .redirect(redirect), .redirect_addr(redirectAddr),
        .d_valid(dValid[0]), .d_ready(dReady), .d_inst(dInst[0]), .d_pc(dPc[0]),
        .bubble_cnt(bubbleCnt[0]));

    fetch_buffer #(.ADDR_W(7), .QDEPTH(2), .RESET_PC(RESET_PC_TB)) dut2 (
        .clk(clk), .rst(rst), .imem_en(imemEn[1]), .imem_addr(imemAddr[1]),
        .imem_rdata(imemRdata[1]), .redirect(redirect), .redirect_addr(redirectAddr),
        .d_valid(dValid[1]), .d_ready(dReady), .d_inst(dInst[1]), .d_pc(dPc[1]),
        .bubble_cnt(bubbleCnt[1]));

    fetch_buffer #(.ADDR_W(7), .QDEPTH(8), .RESET_PC(RESET_PC_TB)) dut8 (
        .clk(clk), .rst(rst), .imem_en(imemEn[2]), .imem_addr(imemAddr[2]),
        .imem_rdata(imemRdata[2]), .redirect(redirect), .redirect_addr(redirectAddr),
        .d_valid(dValid[2]), .d_ready(dReady), .d_inst(dInst[2]), .d_pc(dPc[2]),
        .bubble_cnt(bubbleCnt[2]));

    function automatic logic [31:0] memWord(input logic [6:0] a);
        return 32'(a) + 32'd100;
    endfunction

    function automatic int depthOf(input int k);
        case (k)
            0:       return 4;
            1:       return 2;
            default: return 8;
        endcase
    endfunction

    // Synchronous instruction memory: imem[i] = i + 100, one-cycle read latency.
    always @(posedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (imemEn[k]) imemRdata[k] <= memWord(imemAddr[k]);
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic modelReset(input int k);
        mPc[k]      = RESET_PC_TB;
        mReqPc[k]   = RESET_PC_TB;
        mBubble[k]  = 32'd0;
        mInfl[k]    = 1'b0;
        mCount[k]   = 0;
        mHead[k]    = 0;
        obsCount[k] = 0;
        obsInfl[k]  = 1'b0;
    endtask

    // Compares every instance with its model for the current cycle, then advances the model.
    task automatic modelStep();
        for (int k = 0; k < 3; k++) begin
            logic        v;
            logic        pop;
            logic        issue;
            logic        pushObs;
            logic        popObs;
            logic [31:0] eInst;
            logic [31:0] ePc;
            logic [6:0]  eAddr;
            string       pfx;
            int          tail;
            int          nextObs;

            pfx   = $sformatf("q%0d", depthOf(k));
            v     = (mCount[k] != 0);
            eInst = v ? mInst[k][mHead[k]] : 32'd0;
            ePc   = v ? mDpc[k][mHead[k]]  : 32'd0;
            pop   = v && dReady;
            issue = !rst && !redirect &&
                    ((mCount[k] + int'(mInfl[k]) - int'(pop)) < depthOf(k));
            eAddr = rst ? RESET_PC_TB[8:2] : mPc[k][8:2];

            checkOutput({pfx, ".d_valid"},    32'(dValid[k]),   32'(v));
            checkOutput({pfx, ".d_inst"},     dInst[k],         eInst);
            checkOutput({pfx, ".d_pc"},       dPc[k],           ePc);
            checkOutput({pfx, ".imem_en"},    32'(imemEn[k]),   32'(issue));
            checkOutput({pfx, ".imem_addr"},  32'(imemAddr[k]), 32'(eAddr));
            checkOutput({pfx, ".bubble_cnt"}, bubbleCnt[k],     mBubble[k]);

            pushObs = obsInfl[k] && !rst && !redirect;
            popObs  = dValid[k] && dReady;
            nextObs = obsCount[k] + int'(pushObs) - int'(popObs);
            checkOutput({pfx, ".noOverflow"}, 32'(nextObs <= depthOf(k)), 32'd1);
            obsCount[k] = (rst || redirect) ? 0 : nextObs;
            obsInfl[k]  = imemEn[k];

            if (rst) begin
                modelReset(k);
            end else begin
                if (dReady && !v && mBubble[k] != 32'hFFFF_FFFF) mBubble[k] = mBubble[k] + 32'd1;
                if (redirect) begin
                    mCount[k] = 0;
                    mHead[k]  = 0;
                    mInfl[k]  = 1'b0;
                    mPc[k]    = {redirectAddr[31:2], 2'b00};
                end else begin
                    if (pop) begin
                        mHead[k]  = (mHead[k] + 1) % 8;
                        mCount[k] = mCount[k] - 1;
                    end
                    if (mInfl[k]) begin
                        tail           = (mHead[k] + mCount[k]) % 8;
                        mInst[k][tail] = memWord(mReqPc[k][8:2]);
                        mDpc[k][tail]  = mReqPc[k] + 32'd4;
                        mCount[k]      = mCount[k] + 1;
                    end
                    if (issue) begin
                        mReqPc[k] = mPc[k];
                        mInfl[k]  = 1'b1;
                        mPc[k]    = mPc[k] + 32'd4;
                    end else begin
                        mInfl[k] = 1'b0;
                    end
                end
            end
        end
    endtask

    // Drives one cycle of inputs just after the rising edge and samples on the falling edge.
    task automatic applyStimulus(input logic r, input logic red, input logic [31:0] ra, input logic rdy);
        @(posedge clk);
        #1;
        rst          = r;
        redirect     = red;
        redirectAddr = ra;
        dReady       = rdy;
        @(negedge clk);
        modelStep();
    endtask

    initial begin
        int enCount;
        int pct;

        rst          = 1'b1;
        redirect     = 1'b0;
        redirectAddr = 32'd0;
        dReady       = 1'b0;
        for (int k = 0; k < 3; k++) modelReset(k);

        // Reset state, then streaming with decode always ready.
        applyStimulus(1'b1, 1'b0, 32'd0, 1'b1);
        checkOutput("rst.d_valid",    32'(dValid[0]),   32'd0);
        checkOutput("rst.d_inst",     dInst[0],         32'd0);
        checkOutput("rst.d_pc",       dPc[0],           32'd0);
        checkOutput("rst.imem_en",    32'(imemEn[0]),   32'd0);
        checkOutput("rst.imem_addr",  32'(imemAddr[0]), 32'd0);
        checkOutput("rst.bubble_cnt", bubbleCnt[0],     32'd0);
        applyStimulus(1'b1, 1'b0, 32'd0, 1'b1);
        applyStimulus(1'b0, 1'b0, 32'd0, 1'b1);
        checkOutput("stream.c0.imem_en",   32'(imemEn[0]),   32'd1);
        checkOutput("stream.c0.imem_addr", 32'(imemAddr[0]), 32'd0);
        checkOutput("stream.c0.d_valid",   32'(dValid[0]),   32'd0);
        applyStimulus(1'b0, 1'b0, 32'd0, 1'b1);
        checkOutput("stream.c1.imem_addr", 32'(imemAddr[0]), 32'd1);
        checkOutput("stream.c1.d_valid",   32'(dValid[0]),   32'd0);
        applyStimulus(1'b0, 1'b0, 32'd0, 1'b1);
        checkOutput("stream.c2.d_valid",    32'(dValid[0]), 32'd1);
        checkOutput("stream.c2.d_inst",     dInst[0],       32'd100);
        checkOutput("stream.c2.d_pc",       dPc[0],         32'd4);
        checkOutput("stream.c2.bubble_cnt", bubbleCnt[0],   32'd2);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b0, 1'b0, 32'd0, 1'b1);
            checkOutput("stream.d_inst",     dInst[0],     32'd101 + 32'(i));
            checkOutput("stream.d_pc",       dPc[0],       32'd8 + 32'(4 * i));
            checkOutput("stream.bubble_cnt", bubbleCnt[0], 32'd2);
        end

        // Decode stalled from reset: FIFO fills, fetch stops, then drains without gaps.
        applyStimulus(1'b1, 1'b0, 32'd0, 1'b0);
        enCount = 0;
        for (int c = 0; c < 8; c++) begin
            applyStimulus(1'b0, 1'b0, 32'd0, 1'b0);
            if (imemEn[0]) enCount++;
        end
        checkOutput("fill.en_pulses",  32'(enCount),    32'd4);
        checkOutput("fill.d_valid",    32'(dValid[0]),  32'd1);
        checkOutput("fill.d_inst",     dInst[0],        32'd100);
        checkOutput("fill.bubble_cnt", bubbleCnt[0],    32'd0);
        applyStimulus(1'b0, 1'b0, 32'd0, 1'b1);
        checkOutput("drain.imem_en", 32'(imemEn[0]), 32'd1);
        checkOutput("drain.d_inst",  dInst[0],       32'd100);
        for (int i = 1; i <= 4; i++) begin
            applyStimulus(1'b0, 1'b0, 32'd0, 1'b1);
            checkOutput("drain.d_valid", 32'(dValid[0]), 32'd1);
            checkOutput("drain.d_inst",  dInst[0],       32'd100 + 32'(i));
        end

        // Redirect to 0x23 with three entries buffered and a read in flight.
        applyStimulus(1'b1, 1'b0, 32'd0, 1'b0);
        for (int c = 0; c < 4; c++) applyStimulus(1'b0, 1'b0, 32'd0, 1'b0);
        applyStimulus(1'b0, 1'b1, 32'h0000_0023, 1'b0);
        checkOutput("redir.r.imem_en", 32'(imemEn[0]), 32'd0);
        checkOutput("redir.r.d_valid", 32'(dValid[0]), 32'd1);
        applyStimulus(1'b0, 1'b0, 32'd0, 1'b0);
        checkOutput("redir.r1.d_valid",   32'(dValid[0]),   32'd0);
        checkOutput("redir.r1.d_inst",    dInst[0],         32'd0);
        checkOutput("redir.r1.d_pc",      dPc[0],           32'd0);
        checkOutput("redir.r1.imem_en",   32'(imemEn[0]),   32'd1);
        checkOutput("redir.r1.imem_addr", 32'(imemAddr[0]), 32'd8);
        applyStimulus(1'b0, 1'b0, 32'd0, 1'b0);
        checkOutput("redir.r2.d_valid",   32'(dValid[0]),   32'd0);
        checkOutput("redir.r2.imem_addr", 32'(imemAddr[0]), 32'd9);
        applyStimulus(1'b0, 1'b0, 32'd0, 1'b1);
        checkOutput("redir.r3.d_valid", 32'(dValid[0]), 32'd1);
        checkOutput("redir.r3.d_inst",  dInst[0],       32'd108);
        checkOutput("redir.r3.d_pc",    dPc[0],         32'h24);
        applyStimulus(1'b0, 1'b0, 32'd0, 1'b1);
        checkOutput("redir.r4.d_inst", dInst[0], 32'd109);
        checkOutput("redir.r4.d_pc",   dPc[0],   32'h28);

        // Redirect coincident with a pop and a returning read, then back-to-back redirects.
        applyStimulus(1'b1, 1'b0, 32'd0, 1'b1);
        for (int c = 0; c < 3; c++) applyStimulus(1'b0, 1'b0, 32'd0, 1'b1);
        applyStimulus(1'b0, 1'b1, 32'h0000_0040, 1'b1);
        checkOutput("popredir.d_valid", 32'(dValid[0]), 32'd1);
        checkOutput("popredir.d_inst",  dInst[0],       32'd101);
        checkOutput("popredir.imem_en", 32'(imemEn[0]), 32'd0);
        applyStimulus(1'b0, 1'b0, 32'd0, 1'b1);
        checkOutput("popredir.r1.d_valid",   32'(dValid[0]),   32'd0);
        checkOutput("popredir.r1.d_inst",    dInst[0],         32'd0);
        checkOutput("popredir.r1.imem_addr", 32'(imemAddr[0]), 32'd16);
        applyStimulus(1'b0, 1'b0, 32'd0, 1'b1);
        checkOutput("popredir.r2.d_valid", 32'(dValid[0]), 32'd0);
        applyStimulus(1'b0, 1'b0, 32'd0, 1'b1);
        checkOutput("popredir.r3.d_inst",     dInst[0],     32'd116);
        checkOutput("popredir.r3.d_pc",       dPc[0],       32'h44);
        checkOutput("popredir.r3.bubble_cnt", bubbleCnt[0], 32'd4);
        applyStimulus(1'b0, 1'b1, 32'h0000_0010, 1'b1);
        applyStimulus(1'b0, 1'b1, 32'h0000_0031, 1'b1);
        checkOutput("b2b.r.imem_en", 32'(imemEn[0]), 32'd0);
        applyStimulus(1'b0, 1'b0, 32'd0, 1'b1);
        checkOutput("b2b.r1.imem_en",   32'(imemEn[0]),   32'd1);
        checkOutput("b2b.r1.imem_addr", 32'(imemAddr[0]), 32'd12);
        checkOutput("b2b.r1.d_valid",   32'(dValid[0]),   32'd0);
        applyStimulus(1'b0, 1'b0, 32'd0, 1'b1);
        applyStimulus(1'b0, 1'b0, 32'd0, 1'b1);
        checkOutput("b2b.r3.d_inst", dInst[0], 32'd112);
        checkOutput("b2b.r3.d_pc",   dPc[0],   32'h34);

        // One-cycle reset in the middle of a stream.
        applyStimulus(1'b0, 1'b0, 32'd0, 1'b1);
        applyStimulus(1'b0, 1'b0, 32'd0, 1'b1);
        applyStimulus(1'b1, 1'b0, 32'd0, 1'b1);
        checkOutput("midrst.imem_en",   32'(imemEn[0]),   32'd0);
        checkOutput("midrst.imem_addr", 32'(imemAddr[0]), 32'd0);
        applyStimulus(1'b0, 1'b0, 32'd0, 1'b1);
        checkOutput("midrst.c0.d_valid",    32'(dValid[0]),   32'd0);
        checkOutput("midrst.c0.d_inst",     dInst[0],         32'd0);
        checkOutput("midrst.c0.d_pc",       dPc[0],           32'd0);
        checkOutput("midrst.c0.bubble_cnt", bubbleCnt[0],     32'd0);
        checkOutput("midrst.c0.imem_en",    32'(imemEn[0]),   32'd1);
        checkOutput("midrst.c0.imem_addr",  32'(imemAddr[0]), 32'd0);
        applyStimulus(1'b0, 1'b0, 32'd0, 1'b1);
        applyStimulus(1'b0, 1'b0, 32'd0, 1'b1);
        checkOutput("midrst.c2.d_inst",     dInst[0],     32'd100);
        checkOutput("midrst.c2.d_pc",       dPc[0],       32'd4);
        checkOutput("midrst.c2.bubble_cnt", bubbleCnt[0], 32'd2);

        // Seeded random ready/redirect traffic, every instance against its model.
        void'($urandom(32'd20240611));
        applyStimulus(1'b1, 1'b0, 32'd0, 1'b0);
        for (int seg = 0; seg < 3; seg++) begin
            pct = (seg == 0) ? 20 : ((seg == 1) ? 50 : 90);
            for (int c = 0; c < 120; c++) begin
                logic        rdy;
                logic        red;
                logic [31:0] ra;
                rdy = ($urandom_range(0, 99) < pct);
                red = ($urandom_range(0, 29) == 0);
                ra  = $urandom;
                applyStimulus(1'b0, red, ra, rdy);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
